// File: rtl/multicycle_ctrl.sv
// Purpose: Moore-FSM control unit for a multicycle RV32I subset datapath (drives ALU, muxes, enables).
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles; control outputs are registered per state.
// Backpressure: none; the datapath always accepts one control word per cycle, and illegal encodings halt until reset.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             pcwrite,
  output logic             adrsrc,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic [1:0]       resultsrc,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       immsrc,
  output logic [2:0]       alucontrol,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       halted;
  } ctrl_t;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             f3_alu_ok;
  logic             zero_true;

  // Control word asserted while sitting in a given state.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.irwrite = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.pcupdate = 1'b1; end
      S_DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      S_MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      S_MEMREAD:  begin c.adrsrc = 1'b1; end
      S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_EXECR:    begin c.alusrca = 2'b10; c.alusrcb = 2'b00; c.aluop = 2'b10; end
      S_EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      S_ALUWB:    begin c.regwrite = 1'b1; end
      S_BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
      S_HALT:     begin c.halted = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection, the control word for that state, and the retire count.
  always_comb begin
    f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);
    state_d = state_q;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:   state_d = (f3_alu_ok && !(funct7b5 && funct3 != 3'b000)) ? S_EXECR : S_HALT;
          OP_I:   state_d = f3_alu_ok ? S_EXECI : S_HALT;
          OP_BEQ: state_d = (funct3 == 3'b000) ? S_BEQ : S_HALT;
          OP_JAL: state_d = S_JAL;
          default: state_d = S_HALT;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_RESET;
    endcase
    ctrl_d = ctrl_for(state_d);
    // Returning to FETCH from anything but RESET means an instruction just completed.
    if (state_d == S_FETCH && state_q != S_RESET) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  // State, registered control word and counter; reset aborts any in-flight instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_RESET;
      ctrl_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      instret_q <= instret_d;
    end
  end

  // ALU op from the registered aluop class; funct fields come straight from the held instruction.
  always_comb begin
    alucontrol = 3'b000;
    case (ctrl_q.aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    immsrc = 2'b00;
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // A floating or unknown zero flag must never take a branch.
  assign zero_true = (zero === 1'b1);
  assign pcwrite   = ctrl_q.pcupdate | (ctrl_q.branch & zero_true);
  assign adrsrc    = ctrl_q.adrsrc;
  assign memwrite  = ctrl_q.memwrite;
  assign irwrite   = ctrl_q.irwrite;
  assign regwrite  = ctrl_q.regwrite;
  assign resultsrc = ctrl_q.resultsrc;
  assign alusrca   = ctrl_q.alusrca;
  assign alusrcb   = ctrl_q.alusrcb;
  assign halted    = ctrl_q.halted;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        pcwrite, adrsrc, memwrite, irwrite, regwrite, halted;
  logic [1:0]  resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0]  alucontrol;
  logic [31:0] instret;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_instret = 32'd0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .alucontrol(alucontrol), .halted(halted), .instret(instret)
  );

  // Phases an instruction passes through, and instruction classes.
  localparam int P_RESET = 0, P_FETCH = 1, P_DECODE = 2, P_MA = 3, P_MR = 4, P_MWB = 5,
                 P_MWR = 6, P_ER = 7, P_EI = 8, P_AW = 9, P_BEQ = 10, P_JAL = 11, P_HALT = 12;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  function automatic int kind_of(logic [6:0] o, logic [2:0] f3, logic f7);
    bit ok;
    ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return (ok && !(f7 && f3 != 3'd0)) ? K_R : K_ILL;
      7'b0010011: return ok ? K_I : K_ILL;
      7'b1100011: return (f3 == 3'd0) ? K_BEQ : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int n_phases(int k);
    case (k)
      K_LW:  return 5;
      K_BEQ: return 3;
      K_ILL: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int phase_at(int k, int i);
    if (i == 0) return P_FETCH;
    if (i == 1) return P_DECODE;
    case (k)
      K_LW:  return (i == 2) ? P_MA : (i == 3) ? P_MR : P_MWB;
      K_SW:  return (i == 2) ? P_MA : P_MWR;
      K_R:   return (i == 2) ? P_ER : P_AW;
      K_I:   return (i == 2) ? P_EI : P_AW;
      K_BEQ: return P_BEQ;
      K_JAL: return (i == 2) ? P_JAL : P_AW;
      default: return P_HALT;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu_exec(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // {pcwrite,adrsrc,memwrite,irwrite,regwrite,resultsrc,alusrca,alusrcb,alucontrol,halted}
  function automatic logic [14:0] exp_vec(int ph, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic pcw, adr, mw, irw, rw, h;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac;
    {pcw, adr, mw, irw, rw, h} = '0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
    case (ph)
      P_FETCH:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      P_DECODE: begin sa = 2'b01; sb = 2'b01; end
      P_MA:     begin sa = 2'b10; sb = 2'b01; end
      P_MR:     adr = 1;
      P_MWB:    begin rs = 2'b01; rw = 1; end
      P_MWR:    begin adr = 1; mw = 1; end
      P_ER:     begin sa = 2'b10; ac = exp_alu_exec(o, f3, f7); end
      P_EI:     begin sa = 2'b10; sb = 2'b01; ac = exp_alu_exec(o, f3, f7); end
      P_AW:     rw = 1;
      P_BEQ:    begin sa = 2'b10; ac = 3'b001; pcw = (z === 1'b1); end
      P_JAL:    begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      P_HALT:   h = 1;
      default:  ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, h};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb, alucontrol, halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
    tick(); tick();
    checks++; if (obs_vec() !== 15'd0) $display("FAIL reset_outputs got %b want %b", obs_vec(), 15'd0); else passed++;
    checks++; if (immsrc !== 2'b10) $display("FAIL reset_immsrc got %b want %b", immsrc, 2'b10); else passed++;
    checks++; if (instret !== 32'd0) $display("FAIL reset_instret got %0d want 0", instret); else passed++;
    rst = 1'b1;
    tick();
    checks++; if ({irwrite, pcwrite, alusrcb} !== 4'b1110) $display("FAIL first_fetch got %b want 1110", {irwrite, pcwrite, alusrcb}); else passed++;
    checks++; if (instret !== 32'd0) $display("FAIL first_fetch_instret got %0d want 0", instret); else passed++;
    exp_instret = 32'd0;
  endtask

  task automatic test_rtype_sub();
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    tick(); tick();
    checks++; if (alucontrol !== 3'b001) $display("FAIL rtype_sub_alu got %b want 001", alucontrol); else passed++;
    tick();
    checks++; if (regwrite !== 1'b1) $display("FAIL rtype_aluwb_regwrite got %b want 1", regwrite); else passed++;
    tick();
    exp_instret++;
    checks++; if ({irwrite, instret} !== {1'b1, exp_instret}) $display("FAIL rtype_retire got ir=%b cnt=%0d want ir=1 cnt=%0d", irwrite, instret, exp_instret); else passed++;
  endtask

  task automatic test_lw_sw();
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    tick(); tick(); tick();
    checks++; if (adrsrc !== 1'b1) $display("FAIL lw_memread_adrsrc got %b want 1", adrsrc); else passed++;
    tick();
    checks++; if ({resultsrc, regwrite} !== 3'b011) $display("FAIL lw_memwb got %b want 011", {resultsrc, regwrite}); else passed++;
    tick();
    exp_instret++;
    checks++; if ({irwrite, instret} !== {1'b1, exp_instret}) $display("FAIL lw_retire got ir=%b cnt=%0d want ir=1 cnt=%0d", irwrite, instret, exp_instret); else passed++;
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    checks++; if (immsrc !== 2'b01) $display("FAIL sw_immsrc got %b want 01", immsrc); else passed++;
    tick(); tick(); tick();
    checks++; if ({memwrite, adrsrc} !== 2'b11) $display("FAIL sw_memwrite got %b want 11", {memwrite, adrsrc}); else passed++;
    tick();
    exp_instret++;
    checks++; if ({irwrite, instret} !== {1'b1, exp_instret}) $display("FAIL sw_retire got ir=%b cnt=%0d want ir=1 cnt=%0d", irwrite, instret, exp_instret); else passed++;
  endtask

  task automatic test_beq();
    logic [1:0] zv [3];
    zv[0] = 2'd1; zv[1] = 2'd2; zv[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      logic z;
      logic want;
      z = (zv[i] == 2'd1) ? 1'b1 : (zv[i] == 2'd2) ? 1'bz : 1'b0;
      want = (zv[i] == 2'd1);
      set_instr(7'b1100011, 3'b000, 1'b0, z);
      tick(); tick();
      checks++; if ({pcwrite, alucontrol} !== {want, 3'b001}) $display("FAIL beq_branch_%0d got %b want %b", i, {pcwrite, alucontrol}, {want, 3'b001}); else passed++;
      tick();
      exp_instret++;
      checks++; if (instret !== exp_instret) $display("FAIL beq_retire_%0d got %0d want %0d", i, instret, exp_instret); else passed++;
    end
  endtask

  task automatic test_itype();
    logic [2:0] f3s [4];
    logic [2:0] want [4];
    f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111;
    want[0] = 3'b000; want[1] = 3'b101; want[2] = 3'b011; want[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      set_instr(7'b0010011, f3s[i], 1'b1, 1'b0);
      tick(); tick();
      checks++; if (alucontrol !== want[i]) $display("FAIL itype_alu_f3_%b got %b want %b", f3s[i], alucontrol, want[i]); else passed++;
      tick(); tick();
      exp_instret++;
    end
    checks++; if (instret !== exp_instret) $display("FAIL itype_retire got %0d want %0d", instret, exp_instret); else passed++;
  endtask

  task automatic test_jal();
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    checks++; if (immsrc !== 2'b11) $display("FAIL jal_immsrc got %b want 11", immsrc); else passed++;
    tick(); tick();
    checks++; if ({pcwrite, alusrca, alusrcb} !== 5'b10110) $display("FAIL jal_state got %b want 10110", {pcwrite, alusrca, alusrcb}); else passed++;
    tick();
    checks++; if (regwrite !== 1'b1) $display("FAIL jal_aluwb got %b want 1", regwrite); else passed++;
    tick();
    exp_instret++;
    checks++; if (instret !== exp_instret) $display("FAIL jal_retire got %0d want %0d", instret, exp_instret); else passed++;
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic [2:0] legal_f3 [4];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd2; legal_f3[2] = 3'd6; legal_f3[3] = 3'd7;
    for (int n = 0; n < 80; n++) begin
      logic [6:0] o;
      logic [2:0] f3;
      logic f7;
      int k;
      o  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f3 = (o == 7'b1100011) ? 3'd0 : legal_f3[$urandom_range(0, 3)];
      f7 = ($urandom_range(0, 3) == 0);
      k  = kind_of(o, f3, f7);
      for (int i = 0; i < n_phases(k); i++) begin
        int ph;
        logic z;
        ph = phase_at(k, i);
        z = ($urandom_range(0, 2) == 0) ? 1'bz : 1'($urandom);
        set_instr(o, f3, f7, z);
        checks++; if (obs_vec() !== exp_vec(ph, o, f3, f7, z)) $display("FAIL rand_ctrl n=%0d ph=%0d op=%b got %b want %b", n, ph, o, obs_vec(), exp_vec(ph, o, f3, f7, z)); else passed++;
        checks++; if ({immsrc, instret} !== {exp_imm(o), exp_instret}) $display("FAIL rand_imm_cnt n=%0d got %b/%0d want %b/%0d", n, immsrc, instret, exp_imm(o), exp_instret); else passed++;
        tick();
      end
      if (k == K_ILL) begin
        checks++; if ({halted, instret} !== {1'b1, exp_instret}) $display("FAIL rand_halt_hold n=%0d got %b/%0d want 1/%0d", n, halted, instret, exp_instret); else passed++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_instret = 32'd0;
        checks++; if ({obs_vec(), instret} !== {15'd0, 32'd0}) $display("FAIL rand_reset n=%0d got %b/%0d want 0/0", n, obs_vec(), instret); else passed++;
        tick();
      end else begin
        exp_instret++;
      end
    end
  endtask

  task automatic test_abort();
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_instret = 32'd0;
    checks++; if ({obs_vec(), instret} !== {15'd0, 32'd0}) $display("FAIL abort_reset got %b/%0d want 0/0", obs_vec(), instret); else passed++;
    tick();
    checks++; if ({irwrite, instret} !== {1'b1, 32'd0}) $display("FAIL abort_refetch got %b/%0d want 1/0", irwrite, instret); else passed++;
  endtask

  task automatic test_halt();
    logic [31:0] held;
    set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    exp_instret++;
    held = exp_instret;
    set_instr(7'b1110011, 3'b000, 1'b0, 1'b0);
    tick(); tick();
    checks++; if (halted !== 1'b1) $display("FAIL halt_enter got %b want 1", halted); else passed++;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({halted, instret} !== {1'b1, held}) $display("FAIL halt_hold_%0d got %b/%0d want 1/%0d", i, halted, instret, held); else passed++;
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_instret = 32'd0;
    checks++; if ({obs_vec(), instret} !== {15'd0, 32'd0}) $display("FAIL halt_reset got %b/%0d want 0/0", obs_vec(), instret); else passed++;
    tick();
    checks++; if ({irwrite, pcwrite, halted} !== 3'b110) $display("FAIL halt_refetch got %b want 110", {irwrite, pcwrite, halted}); else passed++;
  endtask

  initial begin
    rst = 1'b0;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    #2;
    test_reset();
    test_rtype_sub();
    test_lw_sw();
    test_beq();
    test_itype();
    test_jal();
    test_abort();
    test_random();
    test_halt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
